// File: rtl/miriscv_irq_ctrl.sv
// Interrupt controller feeding the miriscv_core trap path.
// Level-sensitive requests are masked by mie and picked by a sequential
// scan (lowest index reached first wins). The chosen line is held in
// service until the core executes mret; the device then gets a one-hot
// acknowledge pulse.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no service in progress, waiting for any pending line
// ST_SCAN    | walking cnt upward from 0 looking for a pending line
// ST_SERVICE | trap issued for line id, waiting for mret from the core
module miriscv_irq_ctrl #(
    parameter int N_IRQ = 32,
    localparam int CNT_W = $clog2(N_IRQ)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic             mret_i,
    output logic             int_o,
    output logic [31:0]      mcause_o,
    output logic [N_IRQ-1:0] irq_ret_o,
    output logic             busy_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SCAN    = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IRQ - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [N_IRQ-1:0] RET_BIT0 = N_IRQ'(1);

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] id_q,     id_d;
    logic             int_q,    int_d;
    logic [31:0]      mcause_q, mcause_d;
    logic [N_IRQ-1:0] ret_q,    ret_d;
    logic [N_IRQ-1:0] pend;

    assign pend = irq_req_i & mie_i;

    // Next-state logic: scan, service entry (trap + cause) and return (ack).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        int_d    = 1'b0;
        mcause_d = mcause_q;
        ret_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (|pend) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (pend[cnt_q]) begin
                    state_d  = ST_SERVICE;
                    id_d     = cnt_q;
                    int_d    = 1'b1;
                    // Interrupt bit set, exception code = line index.
                    mcause_d = {1'b1, 26'b0, 5'(cnt_q)};
                end else if (cnt_q == CNT_LAST) begin
                    // Request vanished before the counter reached it.
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_SERVICE: begin
                // Requests and mask are deliberately not looked at here:
                // no nesting, and a dropped request still gets its return.
                if (mret_i) begin
                    state_d = ST_IDLE;
                    ret_d   = RET_BIT0 << id_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset aborts any service silently.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            id_q     <= '0;
            int_q    <= 1'b0;
            mcause_q <= '0;
            ret_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            int_q    <= int_d;
            mcause_q <= mcause_d;
            ret_q    <= ret_d;
        end
    end

    assign int_o     = int_q;
    assign mcause_o  = mcause_q;
    assign irq_ret_o = ret_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// Bench for miriscv_irq_ctrl: a fixed vector table for the single-request
// timeline, hand-written corner sequences, then randomized traffic, all
// checked cycle by cycle against a behavioural model of the controller.
module tb_miriscv_irq_ctrl;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] mie;
    logic         mret;
    logic         intr;
    logic [31:0]  mcause;
    logic [N-1:0] ret;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // Behavioural model: scan position and serviced line as plain integers
    // (-1 = none), plus the outputs expected after the next clock edge.
    int           m_scan;
    int           m_svc;
    logic         m_int;
    logic [31:0]  m_mcause;
    logic [N-1:0] m_ret;
    logic         m_busy;

    typedef struct {
        logic [N-1:0] req;
        logic         mret;
        logic         e_int;
        logic [31:0]  e_mcause;
        logic [N-1:0] e_ret;
        logic         e_busy;
    } vec_t;

    vec_t tbl [15];

    always #5 clk = ~clk;

    miriscv_irq_ctrl #(.N_IRQ(N)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .irq_req_i (req),
        .mie_i     (mie),
        .mret_i    (mret),
        .int_o     (intr),
        .mcause_o  (mcause),
        .irq_ret_o (ret),
        .busy_o    (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_scan   = -1;
        m_svc    = -1;
        m_int    = 1'b0;
        m_mcause = '0;
        m_ret    = '0;
        m_busy   = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] m, input logic mr);
        logic [N-1:0] pend;
        pend  = r & m;
        m_int = 1'b0;
        m_ret = '0;
        if (m_svc >= 0) begin
            if (mr) begin
                m_ret = N'(1) << m_svc;
                m_svc = -1;
            end
        end else if (m_scan >= 0) begin
            if (pend[m_scan]) begin
                m_svc    = m_scan;
                m_scan   = -1;
                m_int    = 1'b1;
                m_mcause = 32'h8000_0000 + 32'(m_svc);
            end else if (m_scan == N - 1) begin
                m_scan = -1;
            end else begin
                m_scan = m_scan + 1;
            end
        end else if (pend != '0) begin
            m_scan = 0;
        end
        m_busy = (m_scan >= 0) || (m_svc >= 0);
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] m, input logic mr);
        req  = r;
        mie  = m;
        mret = mr;
        model_step(r, m, mr);
        @(posedge clk);
        #1;
        chk("int_o",     32'(intr),  32'(m_int));
        chk("mcause_o",  mcause,     m_mcause);
        chk("irq_ret_o", ret,        m_ret);
        chk("busy_o",    32'(busy),  32'(m_busy));
    endtask

    task automatic run_until_int(input logic [N-1:0] r, input logic [N-1:0] m, input string name);
        int n;
        n = 0;
        do begin
            step(r, m, 1'b0);
            n++;
        end while (!m_int && n < 64);
        chk(name, 32'(intr), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        mie   = '0;
        mret  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] mk;
        logic         mr;
        int           ints;

        // Single request on line 5: cycle timeline, outputs seen at cycle i+1.
        for (int i = 0; i < 15; i++) begin
            tbl[i].req      = (i < 13) ? 32'h0000_0020 : 32'h0;
            tbl[i].mret     = (i == 12);
            tbl[i].e_int    = (i == 6);
            tbl[i].e_mcause = (i >= 6) ? 32'h8000_0005 : 32'h0;
            tbl[i].e_ret    = (i == 12) ? 32'h0000_0020 : 32'h0;
            tbl[i].e_busy   = (i < 12);
        end

        do_reset();
        chk("reset_int",    32'(intr), 32'd0);
        chk("reset_mcause", mcause,    32'd0);
        chk("reset_ret",    ret,       32'd0);
        chk("reset_busy",   32'(busy), 32'd0);

        // Reset while line 3 is in service.
        run_until_int(32'h8, '1, "svc3_int");
        step(32'h8, '1, 1'b0);
        step(32'h8, '1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_int",    32'(intr), 32'd0);
        chk("rst_mid_mcause", mcause,    32'd0);
        chk("rst_mid_ret",    ret,       32'd0);
        chk("rst_mid_busy",   32'(busy), 32'd0);
        model_reset();
        req = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step('0, '1, 1'b0);

        // Vector table for the single-request case.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].req, '1, tbl[i].mret);
            chk($sformatf("tbl%0d_int", i),    32'(intr), 32'(tbl[i].e_int));
            chk($sformatf("tbl%0d_mcause", i), mcause,    tbl[i].e_mcause);
            chk($sformatf("tbl%0d_ret", i),    ret,       tbl[i].e_ret);
            chk($sformatf("tbl%0d_busy", i),   32'(busy), 32'(tbl[i].e_busy));
        end

        // Masking: line 0 requested but disabled.
        run_until_int(32'h11, 32'h10, "mask_int");
        chk("mask_mcause", mcause, 32'h8000_0004);
        step(32'h11, 32'h10, 1'b0);
        step(32'h11, 32'h10, 1'b1);
        chk("mask_ret", ret, 32'h10);
        for (int i = 0; i < 8; i++) begin
            step(32'h01, 32'h10, 1'b0);
            chk("mask_no_ret0", ret, 32'h0);
        end

        // Priority and no nesting.
        run_until_int(32'h204, '1, "prio_int2");
        chk("prio_mcause2", mcause, 32'h8000_0002);
        ints = 0;
        for (int i = 0; i < 4; i++) begin
            step(32'h206, '1, 1'b0);
            ints += int'(intr);
        end
        chk("nest_no_int", 32'(ints), 32'd0);
        step(32'h206, '1, 1'b1);
        chk("prio_ret2", ret, 32'h4);
        run_until_int(32'h202, '1, "prio_int1");
        chk("prio_mcause1", mcause, 32'h8000_0001);
        step(32'h202, '1, 1'b1);
        chk("prio_ret1", ret, 32'h2);
        run_until_int(32'h200, '1, "prio_int9");
        chk("prio_mcause9", mcause, 32'h8000_0009);
        step(32'h200, '1, 1'b1);
        chk("prio_ret9", ret, 32'h200);
        step('0, '1, 1'b0);

        // Withdrawn request: two-cycle pulse on line 20.
        ints = 0;
        step(32'h0010_0000, '1, 1'b0);
        ints += int'(intr);
        step(32'h0010_0000, '1, 1'b0);
        ints += int'(intr);
        for (int i = 0; i < 40; i++) begin
            step('0, '1, 1'b0);
            ints += int'(intr);
        end
        chk("withdraw_int_count", 32'(ints), 32'd0);
        chk("withdraw_busy",      32'(busy), 32'd0);
        chk("withdraw_mcause",    mcause,    32'h8000_0009);

        // mret in IDLE and SCAN is ignored; mret with int_o is the return.
        step('0, '1, 1'b1);
        chk("mret_idle_ret",  ret,       32'h0);
        chk("mret_idle_busy", 32'(busy), 32'd0);
        step(32'h10, '1, 1'b0);
        step(32'h10, '1, 1'b1);
        step(32'h10, '1, 1'b1);
        chk("mret_scan_busy", 32'(busy), 32'd1);
        run_until_int(32'h10, '1, "mret_same_int");
        step(32'h10, '1, 1'b1);
        chk("mret_same_ret",  ret,       32'h10);
        chk("mret_same_busy", 32'(busy), 32'd0);
        step('0, '1, 1'b0);

        // Randomized traffic against the model.
        r  = '0;
        mk = $urandom | $urandom;
        for (int i = 0; i < 3000; i++) begin
            if (m_ret != '0) r = r & ~m_ret;
            if ($urandom_range(0, 7) == 0) r = r ^ (N'(1) << $urandom_range(0, N - 1));
            if ($urandom_range(0, 199) == 0) r = '0;
            if ($urandom_range(0, 99) == 0) mk = $urandom | $urandom;
            mr = (m_svc >= 0 || $urandom_range(0, 15) == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
            step(r, mk, mr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
